// File: rtl/cache_read_controller.sv
// rtl/cache_read_controller.sv - read-path controller for a direct-mapped 256 x 256-byte cache
//
// Owns the tag and valid arrays and sequences lookup, line refill from main
// memory and the data-array write. It also selects the requested byte from
// the addressed line.
//
// Address split: tag [31:16], index [15:8], offset [7:0].
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               invalidate every block (taken only in IDLE)
//   cpu_req/cpu_addr    read request; accepted when cpu_req & cpu_ready
//   cpu_ready           high in IDLE unless flush is asserted
//   cpu_valid/cpu_hit   one-cycle response pulse; cpu_hit = 1 for a hit
//   cpu_byte            requested byte, 0 whenever cpu_valid = 0
//   mem_req             line fetch request, held until mem_ack
//   mem_line_addr       {tag, index} of the line being fetched
//   mem_ack/mem_line    fetched line, byte k at bits [8k+7:8k]
//   da_index            data-array index (0 in IDLE)
//   da_we/da_wdata      data-array write strobe and line data
//   da_rdata            data-array read data for da_index, same cycle
//   hit_count           saturating hit counter
//   miss_count          saturating miss counter
module cache_read_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_ready,
    output logic             cpu_valid,
    output logic             cpu_hit,
    output logic [7:0]       cpu_byte,
    output logic             mem_req,
    output logic [23:0]      mem_line_addr,
    input  logic             mem_ack,
    input  logic [2047:0]    mem_line,
    output logic [7:0]       da_index,
    output logic             da_we,
    output logic [2047:0]    da_wdata,
    input  logic [2047:0]    da_rdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic        hit_q;
    logic [255:0] valid;
    logic [15:0] tag_array [0:255];

    logic [15:0] addr_tag;
    logic [7:0]  addr_index;
    logic [7:0]  addr_offset;
    logic        lookup_hit;
    logic        accept;

    assign addr_tag    = addr_q[31:16];
    assign addr_index  = addr_q[15:8];
    assign addr_offset = addr_q[7:0];
    assign lookup_hit  = valid[addr_index] && (tag_array[addr_index] == addr_tag);
    assign accept      = cpu_req && cpu_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cpu_ready     = 1'b0;
        cpu_valid     = 1'b0;
        cpu_hit       = 1'b0;
        cpu_byte      = 8'h00;
        mem_req       = 1'b0;
        mem_line_addr = 24'h000000;
        da_we         = 1'b0;
        da_index      = addr_index;
        da_wdata      = mem_line;
        case (state)
            IDLE: begin
                da_index  = 8'h00;
                cpu_ready = !flush;
                if (cpu_req && !flush) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = lookup_hit ? RESPOND : REFILL;
            end
            REFILL: begin
                mem_req       = 1'b1;
                mem_line_addr = addr_q[31:8];
                if (mem_ack) begin
                    da_we      = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                cpu_valid  = 1'b1;
                cpu_hit    = hit_q;
                cpu_byte   = da_rdata[{addr_offset, 3'b000} +: 8];
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, hit flag, valid bits and statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= 32'h0;
            hit_q      <= 1'b0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && flush) begin
                valid <= '0;
            end
            if (accept) begin
                addr_q <= cpu_addr;
            end
            if (state == LOOKUP) begin
                hit_q <= lookup_hit;
                if (lookup_hit) begin
                    if (hit_count != '1) begin
                        hit_count <= hit_count + 1'b1;
                    end
                end else if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
            if (da_we) begin
                valid[addr_index] <= 1'b1;
            end
        end
    end

    // Tags need no reset: a tag is only consulted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (da_we) begin
            tag_array[addr_index] <= addr_tag;
        end
    end

endmodule

// File: tb/tb_cache_read_controller.sv
// tb/tb_cache_read_controller.sv - directed self-checking bench for cache_read_controller
module tb_cache_read_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             cpu_req;
    logic [31:0]      cpu_addr;
    logic             cpu_ready;
    logic             cpu_valid;
    logic             cpu_hit;
    logic [7:0]       cpu_byte;
    logic             mem_req;
    logic [23:0]      mem_line_addr;
    logic             mem_ack;
    logic [2047:0]    mem_line;
    logic [7:0]       da_index;
    logic             da_we;
    logic [2047:0]    da_wdata;
    logic [2047:0]    da_rdata;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2047:0] darr [0:255];
    logic [2047:0] line_k;
    logic [2047:0] line_5a;

    always #5 clk = ~clk;

    cache_read_controller #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_valid     (cpu_valid),
        .cpu_hit       (cpu_hit),
        .cpu_byte      (cpu_byte),
        .mem_req       (mem_req),
        .mem_line_addr (mem_line_addr),
        .mem_ack       (mem_ack),
        .mem_line      (mem_line),
        .da_index      (da_index),
        .da_we         (da_we),
        .da_wdata      (da_wdata),
        .da_rdata      (da_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // External data array: combinational read, write on rising edge.
    assign da_rdata = darr[da_index];
    always @(posedge clk) begin
        if (da_we) darr[da_index] <= da_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete read. Inputs change on the falling edge, outputs are
    // checked 1 ns later, well away from the rising edge.
    task automatic do_read(input logic [31:0] a, input bit exp_hit, input int n_wait,
                           input logic [2047:0] line, input logic [7:0] exp_byte);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1 chk("ready_idle", {31'b0, cpu_ready}, 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("ready_lookup", {31'b0, cpu_ready}, 32'd0);
        chk("memreq_lookup", {31'b0, mem_req}, 32'd0);
        chk("da_index", {24'b0, da_index}, {24'b0, a[15:8]});
        if (!exp_hit) begin
            for (int w = 0; w < n_wait; w++) begin
                @(negedge clk);
                #1;
                chk("memreq_wait", {31'b0, mem_req}, 32'd1);
                chk("da_we_wait", {31'b0, da_we}, 32'd0);
            end
            @(negedge clk);
            mem_ack  = 1'b1;
            mem_line = line;
            #1;
            chk("memreq_ack", {31'b0, mem_req}, 32'd1);
            chk("mem_line_addr", {8'b0, mem_line_addr}, {8'b0, a[31:8]});
            chk("da_we_ack", {31'b0, da_we}, 32'd1);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("cpu_valid", {31'b0, cpu_valid}, 32'd1);
        chk("cpu_hit", {31'b0, cpu_hit}, {31'b0, exp_hit});
        chk("cpu_byte", {24'b0, cpu_byte}, {24'b0, exp_byte});
        chk("memreq_resp", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("valid_after", {31'b0, cpu_valid}, 32'd0);
        chk("byte_after", {24'b0, cpu_byte}, 32'd0);
        chk("ready_after", {31'b0, cpu_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) darr[i] = '0;
        for (int k = 0; k < 256; k++) line_k[8*k +: 8] = k[7:0];
        line_5a  = {256{8'h5A}};
        reset    = 1'b1;
        flush    = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = 32'h0;
        mem_ack  = 1'b0;
        mem_line = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, cpu_ready}, 32'd1);
        chk("rst_valid", {31'b0, cpu_valid}, 32'd0);
        chk("rst_hit", {31'b0, cpu_hit}, 32'd0);
        chk("rst_memreq", {31'b0, mem_req}, 32'd0);
        chk("rst_da_we", {31'b0, da_we}, 32'd0);
        chk("rst_byte", {24'b0, cpu_byte}, 32'd0);
        chk("rst_mla", {8'b0, mem_line_addr}, 32'd0);
        chk("rst_hitcnt", {28'b0, hit_count}, 32'd0);
        chk("rst_misscnt", {28'b0, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cold miss, ack in the first REFILL cycle
        do_read(32'h12345607, 1'b0, 0, line_k, 8'h07);
        chk("miss_cnt1", {28'b0, miss_count}, 32'd1);

        // Hit on the same line, last byte
        do_read(32'h123456FF, 1'b1, 0, line_k, 8'hFF);
        chk("hit_cnt1", {28'b0, hit_count}, 32'd1);

        // Conflict miss on the same index with two wait cycles
        do_read(32'hABCD5600, 1'b0, 2, line_5a, 8'h5A);
        chk("miss_cnt2", {28'b0, miss_count}, 32'd2);

        // The evicted line misses again
        do_read(32'h12345607, 1'b0, 1, line_k, 8'h07);
        chk("miss_cnt3", {28'b0, miss_count}, 32'd3);

        // flush together with cpu_req: not accepted, valid bits cleared
        @(negedge clk);
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h12345607;
        #1 chk("flush_ready", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        flush   = 1'b0;
        cpu_req = 1'b0;
        #1 chk("flush_noaccept", {31'b0, cpu_ready}, 32'd1);
        do_read(32'h12345607, 1'b0, 0, line_k, 8'h07);
        chk("miss_cnt4", {28'b0, miss_count}, 32'd4);

        // Reset in the middle of a refill
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'hABCD5601;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #1 chk("mid_memreq", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("rst_drop_memreq", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b1;
        mem_line = line_5a;
        #1;
        chk("late_ack_we", {31'b0, da_we}, 32'd0);
        chk("late_ack_memreq", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_valid", {31'b0, cpu_valid}, 32'd0);
        chk("late_ack_misscnt", {28'b0, miss_count}, 32'd0);

        // Hit counter saturation: one miss, then 20 hits
        do_read(32'h12345607, 1'b0, 0, line_k, 8'h07);
        for (int i = 0; i < 20; i++) begin
            do_read(32'h12345600 | i, 1'b1, 0, line_k, i[7:0]);
            chk("hit_cnt_sat", {28'b0, hit_count}, (i + 1 > 15) ? 32'd15 : i + 1);
        end
        chk("miss_cnt_final", {28'b0, miss_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
